mem_io_ctrl: RTL

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

---
 rtl/mem_io_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_io_ctrl.sv
`timescale 1ns/1ps
// mem_io_ctrl: CPU byte bus front end splitting accesses between a local RAM
// and a small memory-mapped IO block (UART TX/RX FIFOs, stop flag, cycle counter).
// Ports:
//   clk_in, rst_in        clock, asynchronous active-low reset
//   mem_a/mem_wr/mem_dout CPU address, write strobe, write byte
//   mem_din               registered read byte (one cycle after the read)
//   io_buffer_full        registered TX near-full indication
//   tx_data/tx_valid      TX FIFO head toward the UART, tx_ready pops it
//   rx_data/rx_valid      single-cycle pushes from the UART receiver
//   program_stop          sticky flag set by a write to 0x30004
module mem_io_ctrl #(
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned TX_DEPTH       = 16,
  parameter int unsigned RX_DEPTH       = 16,
  parameter int unsigned FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_stop
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int unsigned TX_AW     = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW     = TX_AW + 1;
  localparam int unsigned RX_AW     = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW     = RX_AW + 1;

  localparam logic [TX_CW-1:0] TX_CNT_MAX  = TX_CW'(TX_DEPTH);
  localparam logic [TX_CW-1:0] TX_FULL_LVL = TX_CW'(TX_DEPTH - FULL_MARGIN);
  localparam logic [RX_CW-1:0] RX_CNT_MAX  = RX_CW'(RX_DEPTH);

  // Address decode: only mem_a[17:0] is meaningful
  logic is_io_c, sel_data_c, sel_stop_c, sel_b1_c, sel_b2_c, sel_b3_c;
  logic unused_addr_bits;

  assign is_io_c    = (mem_a[17:16] == 2'b11);
  assign sel_data_c = is_io_c && (mem_a[15:0] == 16'h0000);
  assign sel_stop_c = is_io_c && (mem_a[15:0] == 16'h0004);
  assign sel_b1_c   = is_io_c && (mem_a[15:0] == 16'h0005);
  assign sel_b2_c   = is_io_c && (mem_a[15:0] == 16'h0006);
  assign sel_b3_c   = is_io_c && (mem_a[15:0] == 16'h0007);
  assign unused_addr_bits = ^mem_a[31:18];

  // RAM array, not reset
  logic [7:0] ram [RAM_DEPTH];

  always_ff @(posedge clk_in) begin
    if (mem_wr && !is_io_c) ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_dout;
  end

  // TX FIFO
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr, tx_rptr;
  logic [TX_CW-1:0] tx_count, tx_count_nxt_c;
  logic             tx_push_c, tx_push_ok_c, tx_pop_c;
  logic [7:0]       tx_push_data_c;

  assign tx_valid       = (tx_count != '0);
  assign tx_data        = tx_mem[tx_rptr];
  assign tx_pop_c       = tx_valid && tx_ready;
  assign tx_push_c      = mem_wr && ((sel_data_c && (mem_dout != 8'h00)) || sel_stop_c);
  assign tx_push_data_c = sel_stop_c ? 8'h00 : mem_dout;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push
  assign tx_push_ok_c   = tx_push_c && ((tx_count != TX_CNT_MAX) || tx_pop_c);

  always_comb begin
    tx_count_nxt_c = tx_count;
    if (tx_push_ok_c && !tx_pop_c)      tx_count_nxt_c = tx_count + TX_CW'(1);
    else if (!tx_push_ok_c && tx_pop_c) tx_count_nxt_c = tx_count - TX_CW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (tx_push_ok_c) tx_mem[tx_wptr] <= tx_push_data_c;
  end

  // RX FIFO
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr, rx_rptr;
  logic [RX_CW-1:0] rx_count, rx_count_nxt_c;
  logic             rx_push_ok_c, rx_pop_c;

  assign rx_pop_c     = !mem_wr && sel_data_c && (rx_count != '0);
  assign rx_push_ok_c = rx_valid && ((rx_count != RX_CNT_MAX) || rx_pop_c);

  always_comb begin
    rx_count_nxt_c = rx_count;
    if (rx_push_ok_c && !rx_pop_c)      rx_count_nxt_c = rx_count + RX_CW'(1);
    else if (!rx_push_ok_c && rx_pop_c) rx_count_nxt_c = rx_count - RX_CW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rx_push_ok_c) rx_mem[rx_wptr] <= rx_data;
  end

  // Cycle counter and its snapshot
  logic [31:0] cycle_cnt, snap;

  // Read data source select; registered into mem_din below
  logic [7:0] rd_data_c;

  always_comb begin
    rd_data_c = 8'h00;
    if (!is_io_c)        rd_data_c = ram[mem_a[RAM_ADDR_WIDTH-1:0]];
    else if (sel_data_c) rd_data_c = (rx_count != '0) ? rx_mem[rx_rptr] : 8'h00;
    else if (sel_stop_c) rd_data_c = cycle_cnt[7:0];
    else if (sel_b1_c)   rd_data_c = snap[15:8];
    else if (sel_b2_c)   rd_data_c = snap[23:16];
    else if (sel_b3_c)   rd_data_c = snap[31:24];
  end

  // Control state
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din        <= 8'h00;
      io_buffer_full <= 1'b0;
      program_stop   <= 1'b0;
      tx_wptr        <= '0;
      tx_rptr        <= '0;
      tx_count       <= '0;
      rx_wptr        <= '0;
      rx_rptr        <= '0;
      rx_count       <= '0;
      cycle_cnt      <= 32'h0;
      snap           <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;
      if (!mem_wr)               mem_din <= rd_data_c;
      if (!mem_wr && sel_stop_c) snap    <= cycle_cnt;
      if (mem_wr && sel_stop_c)  program_stop <= 1'b1;
      // Based on the next count so the flag lands with the push that crosses the level
      io_buffer_full <= (tx_count_nxt_c >= TX_FULL_LVL);
      tx_count       <= tx_count_nxt_c;
      rx_count       <= rx_count_nxt_c;
      if (tx_push_ok_c) tx_wptr <= tx_wptr + TX_AW'(1);
      if (tx_pop_c)     tx_rptr <= tx_rptr + TX_AW'(1);
      if (rx_push_ok_c) rx_wptr <= rx_wptr + RX_AW'(1);
      if (rx_pop_c)     rx_rptr <= rx_rptr + RX_AW'(1);
    end
  end

endmodule
